// File: rtl/asmd_operand_feeder.sv
// asmd_operand_feeder: operand-pair FIFO feeding a start/ready multiplier,
// capturing each product with a one-cycle result_valid pulse.
// Optional watchdog: define FEEDER_TIMEOUT_EN to abort stalled operations
// after timeout_cycles clocks in WAIT_BUSY/BUSY and raise sticky err.
module asmd_operand_feeder #(
    parameter int word_length    = 4,
    parameter int depth          = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [word_length-1:0]     in_word0,
    input  logic [word_length-1:0]     in_word1,
    output logic [word_length-1:0]     word0,
    output logic [word_length-1:0]     word1,
    output logic                       start,
    input  logic                       mult_ready,
    input  logic [2*word_length-1:0]   product,
    output logic [2*word_length-1:0]   result,
    output logic                       result_valid,
    output logic [$clog2(depth):0]     count,
    output logic                       err
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        BUSY,
        CAPTURE
    } state_t;

    state_t                     state;
    logic [2*word_length-1:0]   mem [depth];
    logic [AW-1:0]              wptr;
    logic [AW-1:0]              rptr;
    logic                       push;
    logic                       pop;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);
    logic [TW-1:0]              tcnt;
`endif

    // Full/empty decisions use only the registered occupancy, so a push
    // into a full FIFO is dropped even when the FSM pops in the same cycle.
    assign in_ready = (count < CW'(depth));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0) && mult_ready;

    // Operand storage; written at the write pointer on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_word0, in_word1};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer with registered start/result_valid; product is sampled on the
    // cycle mult_ready returns so result and result_valid appear together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            word0        <= '0;
            word1        <= '0;
            start        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            tcnt         <= '0;
            err          <= 1'b0;
`endif
        end else begin
            start        <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        {word0, word1} <= mem[rptr];
                        start          <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef FEEDER_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
`ifdef FEEDER_TIMEOUT_EN
                    if (tcnt == TW'(timeout_cycles - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (!mult_ready) begin
                            state <= BUSY;
                        end
                    end
`else
                    if (!mult_ready) begin
                        state <= BUSY;
                    end
`endif
                end
                BUSY: begin
`ifdef FEEDER_TIMEOUT_EN
                    if (tcnt == TW'(timeout_cycles - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (mult_ready) begin
                            result       <= product;
                            result_valid <= 1'b1;
                            state        <= CAPTURE;
                        end
                    end
`else
                    if (mult_ready) begin
                        result       <= product;
                        result_valid <= 1'b1;
                        state        <= CAPTURE;
                    end
`endif
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef FEEDER_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_asmd_operand_feeder.sv
// tb_asmd_operand_feeder: directed sequence with random operands, checked
// against a queue model of the FIFO and a behavioural multiplier.
module tb_asmd_operand_feeder;

    localparam int W = 4;
    localparam int D = 4;
    localparam int T = 64;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_word0;
    logic [W-1:0]     in_word1;
    logic [W-1:0]     word0;
    logic [W-1:0]     word1;
    logic             start;
    logic             mult_ready;
    logic [2*W-1:0]   product;
    logic [2*W-1:0]   result;
    logic             result_valid;
    logic [$clog2(D):0] count;
    logic             err;

    asmd_operand_feeder #(
        .word_length   (W),
        .depth         (D),
        .timeout_cycles(T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word0    (in_word0),
        .in_word1    (in_word1),
        .word0       (word0),
        .word1       (word1),
        .start       (start),
        .mult_ready  (mult_ready),
        .product     (product),
        .result      (result),
        .result_valid(result_valid),
        .count       (count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int rv_cnt    = 0;
    int s0, r0;
    logic [2*W-1:0] mq[$];
    logic [2*W-1:0] cur;
    logic [W-1:0]   ra, rb;

    // Pulse counters for start and result_valid.
    always @(negedge clk) begin
        if (start === 1'b1) start_cnt++;
        if (result_valid === 1'b1) rv_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd();
        ra = W'($urandom_range(0, (1 << W) - 1));
        rb = W'($urandom_range(0, (1 << W) - 1));
    endtask

    // Offer one pair for one cycle; the model keeps it only if it has room.
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_word0 = a;
        in_word1 = b;
        if (mq.size() < D) mq.push_back({a, b});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (start !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 64'(start), 64'(1));
        cur = (mq.size() > 0) ? mq.pop_front() : '0;
        chk({tag, "_word0"}, 64'(word0), 64'(cur[2*W-1:W]));
        chk({tag, "_word1"}, 64'(word1), 64'(cur[W-1:0]));
    endtask

    // Multiplier drops ready one cycle after start, raises it 6 cycles later.
    task automatic complete(input string tag);
        int n = 0;
        logic [2*W-1:0] e;
        e = (2*W)'(cur[2*W-1:W]) * (2*W)'(cur[W-1:0]);
        @(negedge clk);
        mult_ready = 1'b0;
        repeat (6) @(negedge clk);
        product    = (2*W)'(word0) * (2*W)'(word1);
        mult_ready = 1'b1;
        while (result_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rv"}, 64'(result_valid), 64'(1));
        chk({tag, "_result"}, 64'(result), 64'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_word0 = '0; in_word1 = '0;
        mult_ready = 1'b1; product = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_rv", 64'(result_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_words", 64'({word0, word1}), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single operation 3*2.
        push_pair(W'(3), W'(2));
        wait_start("t1");
        complete("t1");
        repeat (3) @(negedge clk);
        #1;
        chk("t1_starts", 64'(start_cnt), 64'(1));
        chk("t1_rvs", 64'(rv_cnt), 64'(1));

        // Fill with multiplier not ready, offer a fifth, then drain in order.
        @(negedge clk);
        mult_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            chk("t2_in_ready", 64'(in_ready), 64'(1));
            rnd();
            push_pair(ra, rb);
        end
        chk("t2_full_count", 64'(count), 64'(D));
        chk("t2_full_ready", 64'(in_ready), 64'(0));
        rnd();
        push_pair(ra, rb);
        chk("t2_fifth_count", 64'(count), 64'(D));
        mult_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            wait_start("t2");
            complete("t2");
        end
        repeat (3) @(negedge clk);
        chk("t2_empty", 64'(count), 64'(0));

        // Full FIFO: push and pop in the same cycle drops the push.
        mult_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            rnd();
            push_pair(ra, rb);
        end
        mult_ready = 1'b1;
        rnd();
        push_pair(ra, rb);
        chk("t3_count", 64'(count), 64'(D - 1));
        chk("t3_issue", 64'(start), 64'(1));
        for (int i = 0; i < D; i++) begin
            wait_start("t3");
            complete("t3");
        end
        repeat (10) @(negedge clk);
        #1;
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("t3_no_extra_start", 64'(start_cnt), 64'(s0));
        chk("t3_empty", 64'(count), 64'(0));

        // Reset while BUSY with one more pair queued.
        @(negedge clk);
        rnd();
        push_pair(ra, rb);
        wait_start("t4");
        @(negedge clk);
        mult_ready = 1'b0;
        rnd();
        push_pair(ra, rb);
        repeat (2) @(negedge clk);
        #2;
        s0 = start_cnt;
        r0 = rv_cnt;
        reset = 1'b1;
        #1;
        chk("t4_count", 64'(count), 64'(0));
        chk("t4_in_ready", 64'(in_ready), 64'(1));
        chk("t4_words", 64'({word0, word1}), 64'(0));
        chk("t4_start", 64'(start), 64'(0));
        chk("t4_result", 64'(result), 64'(0));
        chk("t4_rv", 64'(result_valid), 64'(0));
        chk("t4_err", 64'(err), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        mult_ready = 1'b1;
        mq.delete();
        repeat (10) @(negedge clk);
        #1;
        chk("t4_no_rv", 64'(rv_cnt), 64'(r0));
        chk("t4_no_start", 64'(start_cnt), 64'(s0));
        chk("t4_count_after", 64'(count), 64'(0));

        // Multiplier never drops ready after start.
        @(negedge clk);
        rnd();
        push_pair(ra, rb);
        rnd();
        push_pair(ra, rb);
        wait_start("t5a");
        #1;
        s0 = start_cnt;
        r0 = rv_cnt;
`ifdef FEEDER_TIMEOUT_EN
        begin
            int n = 0;
            while (err !== 1'b1 && n < 80) begin
                @(negedge clk);
                n++;
            end
            chk("t5_err", 64'(err), 64'(1));
            chk("t5_err_latency", 64'(n), 64'(T + 1));
        end
        wait_start("t5b");
        complete("t5b");
        #1;
        chk("t5_err_sticky", 64'(err), 64'(1));
        chk("t5_rvs", 64'(rv_cnt), 64'(r0 + 1));
`else
        repeat (100) @(negedge clk);
        #1;
        chk("t5_err", 64'(err), 64'(0));
        chk("t5_stalled", 64'(start_cnt), 64'(s0));
        chk("t5_no_rv", 64'(rv_cnt), 64'(r0));
        chk("t5_pending", 64'(count), 64'(1));
        complete("t5a");
        wait_start("t5b");
        complete("t5b");
        #1;
        chk("t5_err_end", 64'(err), 64'(0));
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
